reg_file_read_stage: RTL and testbench

- Architectural register file plus registered read stage for the 16-bit WISC core.
- Holds the 16×16 register array built from per-bit storage cells, all on one write port.
- Decode presents two source specifiers per instruction; the block returns both operands one cycle later through a valid/ready handshake into the execute stage.
- Write-back drives the single write port; bypass logic guarantees operands never lag a same-cycle or later write.

---
 rtl/reg_file_read_stage.sv | 121 ++++++++++++
 tb/tb_reg_file_read_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_read_stage.sv
// Architectural register file with a registered, handshaked operand read stage.
// Two source operands are returned one cycle after a request is accepted; the
// write-back port is bypassed into both the accepting read and a held pair.
module reg_file_read_stage #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned IDX_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_valid_in,
  output logic              rd_ready_out,
  input  logic [IDX_W-1:0]  src1_idx,
  input  logic [IDX_W-1:0]  src2_idx,
  input  logic              flush,
  output logic              rd_valid_out,
  input  logic              rd_ready_in,
  output logic [DATA_W-1:0] src1_data,
  output logic [DATA_W-1:0] src2_data,
  output logic [IDX_W-1:0]  src1_idx_q,
  output logic [IDX_W-1:0]  src2_idx_q
);

  // Register storage; entry 0 is never written and is masked on read.
  logic [DATA_W-1:0] regs [NUM_REGS];

  logic              accept;
  logic              hold;
  logic              wr_live;
  logic [DATA_W-1:0] op1_c;
  logic [DATA_W-1:0] op2_c;
  logic              refresh1;
  logic              refresh2;

  // Stage can take a new pair when empty or when the current pair leaves.
  assign rd_ready_out = !rd_valid_out || rd_ready_in;

  // Handshake decode and operand selection with same-cycle write bypass.
  always_comb begin
    accept   = 1'b0;
    hold     = 1'b0;
    wr_live  = 1'b0;
    op1_c    = '0;
    op2_c    = '0;
    refresh1 = 1'b0;
    refresh2 = 1'b0;

    accept  = rd_valid_in && rd_ready_out && !flush;
    hold    = rd_valid_out && !rd_ready_in && !flush;
    wr_live = wr_en && (wr_idx != '0);

    if (src1_idx == '0) begin
      op1_c = '0;
    end else if (wr_en && (wr_idx == src1_idx)) begin
      op1_c = wr_data;
    end else begin
      op1_c = regs[src1_idx];
    end

    if (src2_idx == '0) begin
      op2_c = '0;
    end else if (wr_en && (wr_idx == src2_idx)) begin
      op2_c = wr_data;
    end else begin
      op2_c = regs[src2_idx];
    end

    refresh1 = hold && wr_live && (wr_idx == src1_idx_q);
    refresh2 = hold && wr_live && (wr_idx == src2_idx_q);
  end

  // Single write port; index 0 writes are dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs[i] <= '0;
      end
    end else if (wr_live) begin
      regs[wr_idx] <= wr_data;
    end
  end

  // Output valid: flush wins, then accept, then drain on ready, else hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_valid_out <= 1'b0;
    end else if (flush) begin
      rd_valid_out <= 1'b0;
    end else if (accept) begin
      rd_valid_out <= 1'b1;
    end else if (rd_ready_in) begin
      rd_valid_out <= 1'b0;
    end
  end

  // Operand pair: load on accept, refresh a held pair from write-back.
  always_ff @(posedge clk) begin
    if (!rst) begin
      src1_data  <= '0;
      src2_data  <= '0;
      src1_idx_q <= '0;
      src2_idx_q <= '0;
    end else if (accept) begin
      src1_data  <= op1_c;
      src2_data  <= op2_c;
      src1_idx_q <= src1_idx;
      src2_idx_q <= src2_idx;
    end else begin
      if (refresh1) begin
        src1_data <= wr_data;
      end
      if (refresh2) begin
        src2_data <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_read_stage.sv
// Directed table-driven bench plus throughput and random back-pressure runs.
module tb_reg_file_read_stage;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_idx;
  logic [15:0] wr_data;
  logic        rd_valid_in;
  logic        rd_ready_out;
  logic [3:0]  src1_idx;
  logic [3:0]  src2_idx;
  logic        flush;
  logic        rd_valid_out;
  logic        rd_ready_in;
  logic [15:0] src1_data;
  logic [15:0] src2_data;
  logic [3:0]  src1_idx_q;
  logic [3:0]  src2_idx_q;

  reg_file_read_stage dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .wr_data     (wr_data),
    .rd_valid_in (rd_valid_in),
    .rd_ready_out(rd_ready_out),
    .src1_idx    (src1_idx),
    .src2_idx    (src2_idx),
    .flush       (flush),
    .rd_valid_out(rd_valid_out),
    .rd_ready_in (rd_ready_in),
    .src1_data   (src1_data),
    .src2_data   (src2_data),
    .src1_idx_q  (src1_idx_q),
    .src2_idx_q  (src2_idx_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  wi;
    logic [15:0] wd;
    logic        vi;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic        fl;
    logic        ri;
    logic        erdy;
    logic        ev;
    logic [15:0] e1;
    logic [15:0] e2;
    logic [3:0]  ei1;
    logic [3:0]  ei2;
  } vec_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
  } pair_t;

  vec_t        vecs [19];
  logic [15:0] mregs [16];
  pair_t       pq [$];
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic we, input logic [3:0] wi, input logic [15:0] wd,
                       input logic vi, input logic [3:0] s1, input logic [3:0] s2,
                       input logic fl, input logic ri);
    wr_en = we; wr_idx = wi; wr_data = wd;
    rd_valid_in = vi; src1_idx = s1; src2_idx = s2;
    flush = fl; rd_ready_in = ri;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // we wi wd vi s1 s2 fl ri | erdy ev e1 e2 ei1 ei2
    vecs[0]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd3, 4'd7, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000, 4'd3, 4'd7};
    vecs[1]  = '{1'b1, 4'd5, 16'hBEEF, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 4'd0, 4'd0};
    vecs[2]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd5, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 16'hBEEF, 16'h0000, 4'd5, 4'd0};
    vecs[3]  = '{1'b1, 4'd0, 16'h1234, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 4'd0, 4'd0};
    vecs[4]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000, 4'd0, 4'd0};
    vecs[5]  = '{1'b1, 4'd9, 16'h00A5, 1'b1, 4'd9, 4'd9, 1'b0, 1'b1, 1'b1, 1'b1, 16'h00A5, 16'h00A5, 4'd9, 4'd9};
    vecs[6]  = '{1'b1, 4'd2, 16'h0011, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 4'd0, 4'd0};
    vecs[7]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd2, 4'd5, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0011, 16'hBEEF, 4'd2, 4'd5};
    vecs[8]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0011, 16'hBEEF, 4'd2, 4'd5};
    vecs[9]  = '{1'b1, 4'd2, 16'h2222, 1'b1, 4'd6, 4'd6, 1'b0, 1'b0, 1'b0, 1'b1, 16'h2222, 16'hBEEF, 4'd2, 4'd5};
    vecs[10] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 4'd0, 4'd0};
    vecs[11] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd4, 4'd9, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h00A5, 4'd4, 4'd9};
    vecs[12] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd4, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 4'd0, 4'd0};
    vecs[13] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd2, 4'd5, 1'b0, 1'b1, 1'b1, 1'b1, 16'h2222, 16'hBEEF, 4'd2, 4'd5};
    vecs[14] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h2222, 16'hBEEF, 4'd2, 4'd5};
    vecs[15] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0, 4'd0};
    vecs[16] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd7, 4'd7, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 4'd7, 4'd7};
    vecs[17] = '{1'b1, 4'd7, 16'h7777, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h7777, 16'h7777, 4'd7, 4'd7};
    vecs[18] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 4'd0, 4'd0};

    for (int k = 0; k < 16; k++) mregs[k] = 16'h0000;

    // Reset held for two edges, with a write and a request that must be ignored.
    rst = 1'b0;
    drive(1'b1, 4'd5, 16'hDEAD, 1'b1, 4'd5, 4'd5, 1'b0, 1'b1);
    tick();
    tick();
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("reset_valid", 16'(rd_valid_out), 16'h0);
    check("reset_src1", src1_data, 16'h0);
    check("reset_src2", src2_data, 16'h0);
    check("reset_idx", {8'h0, src1_idx_q, src2_idx_q}, 16'h0);
    check("reset_ready", 16'(rd_ready_out), 16'h1);

    // Directed table.
    for (int v = 0; v < 19; v++) begin
      drive(vecs[v].we, vecs[v].wi, vecs[v].wd, vecs[v].vi, vecs[v].s1, vecs[v].s2,
            vecs[v].fl, vecs[v].ri);
      #1;
      check($sformatf("v%0d_ready", v), 16'(rd_ready_out), 16'(vecs[v].erdy));
      tick();
      check($sformatf("v%0d_valid", v), 16'(rd_valid_out), 16'(vecs[v].ev));
      if (vecs[v].ev) begin
        check($sformatf("v%0d_src1", v), src1_data, vecs[v].e1);
        check($sformatf("v%0d_src2", v), src2_data, vecs[v].e2);
        check($sformatf("v%0d_idx", v), {8'h0, src1_idx_q, src2_idx_q},
              {8'h0, vecs[v].ei1, vecs[v].ei2});
      end
      if (vecs[v].we && vecs[v].wi != 4'd0) mregs[vecs[v].wi] = vecs[v].wd;
    end

    // Throughput: fill R1..R8, then 8 back-to-back reads.
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 4'(k), 16'(16'h1111 * k), 1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
      tick();
      mregs[k] = 16'(16'h1111 * k);
    end
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 4'd0, 16'h0, 1'b1, 4'(k + 1), 4'(8 - k), 1'b0, 1'b1);
      #1;
      check($sformatf("tp%0d_ready", k), 16'(rd_ready_out), 16'h1);
      tick();
      check($sformatf("tp%0d_valid", k), 16'(rd_valid_out), 16'h1);
      check($sformatf("tp%0d_src1", k), src1_data, mregs[k + 1]);
      check($sformatf("tp%0d_src2", k), src2_data, mregs[8 - k]);
    end
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
    tick();
    check("tp_drain_valid", 16'(rd_valid_out), 16'h0);

    // Random back-pressure: every accepted pair must leave exactly once, in order.
    begin
      logic  mvalid;
      logic  vi, ri, acc;
      int    n_acc, n_xfer;
      pair_t p;
      mvalid = 1'b0;
      n_acc = 0;
      n_xfer = 0;
      for (int c = 0; c < 300; c++) begin
        vi = 1'($urandom_range(0, 1));
        ri = 1'($urandom_range(0, 1));
        if (c >= 290) vi = 1'b0;
        if (c >= 290) ri = 1'b1;
        drive(1'b0, 4'd0, 16'h0, vi, 4'($urandom_range(1, 8)), 4'($urandom_range(1, 8)), 1'b0, ri);
        #1;
        check("rnd_valid", 16'(rd_valid_out), 16'(mvalid));
        acc = vi && (!mvalid || ri);
        if (mvalid && ri) begin
          n_xfer++;
          if (pq.size() == 0) begin
            check("rnd_unexpected_xfer", 16'h1, 16'h0);
          end else begin
            p = pq.pop_front();
            check("rnd_src1", src1_data, p.a);
            check("rnd_src2", src2_data, p.b);
          end
        end
        if (acc) begin
          n_acc++;
          p.a = mregs[src1_idx];
          p.b = mregs[src2_idx];
          pq.push_back(p);
        end
        mvalid = acc ? 1'b1 : (ri ? 1'b0 : mvalid);
        tick();
      end
      check("rnd_count", 16'(n_xfer), 16'(n_acc));
      check("rnd_empty", 16'(pq.size()), 16'h0);
    end

    // Reset during a stall clears valid and the array in the same edge.
    drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd3, 4'd5, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    tick();
    check("stall_pre_rst_valid", 16'(rd_valid_out), 16'h1);
    check("stall_pre_rst_src1", src1_data, mregs[3]);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("midrst_valid", 16'(rd_valid_out), 16'h0);
    drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd5, 4'd3, 1'b0, 1'b1);
    tick();
    check("midrst_read_valid", 16'(rd_valid_out), 16'h1);
    check("midrst_src1", src1_data, 16'h0);
    check("midrst_src2", src2_data, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
